// File: rtl/alu_issue_queue_pkg.sv
// ============================================================================
// Module : rs_pkg
// Brief  : Shared widths, entry layout and tag constants for the ALU issue queue
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ROB_W_DEF  = 4;
  localparam int TYPE_W_DEF = 6;

  localparam logic [ROB_W_DEF-1:0] ZERO_TAG = '0;

  // Reference entry layout at the default widths; the queue stores each field
  // in its own array so that the widths can follow the module parameters.
  typedef struct packed {
    logic                  busy;
    logic [TYPE_W_DEF-1:0] op_type;
    logic [DATA_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] imm;
    logic [ROB_W_DEF-1:0]  dest;
    logic [DATA_W_DEF-1:0] vj;
    logic [ROB_W_DEF-1:0]  qj;
    logic                  rj;
    logic [DATA_W_DEF-1:0] vk;
    logic [ROB_W_DEF-1:0]  qk;
    logic                  rk;
  } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/alu_issue_queue_age_select.sv
// ============================================================================
// Module : rs_age_select
// Brief  : Oldest-first one-hot grant from a ready vector and an age matrix
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]       i_ready,
  input  logic [DEPTH*DEPTH-1:0] i_age,    // bit i*DEPTH+j set: entry i older than j
  output logic [DEPTH-1:0]       o_grant,
  output logic                   o_valid
);

  for (genvar j = 0; j < DEPTH; j++) begin : g_col
    logic w_blocked;
    always_comb begin
      w_blocked = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i_ready[i] && i_age[i*DEPTH+j]) w_blocked = 1'b1;
      end
    end
    assign o_grant[j] = i_ready[j] & ~w_blocked;
  end

  assign o_valid = |o_grant;

endmodule

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module : alu_issue_queue
// Brief  : Parametrised ALU reservation station with CDB wakeup and age-ordered issue
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_issue_queue
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int CDB_PORTS = 2,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int TYPE_W    = TYPE_W_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           flush_in,
  input  logic                           dispatch_valid_in,
  output logic                           dispatch_ready_out,
  input  logic [TYPE_W-1:0]              dispatch_type_in,
  input  logic [DATA_W-1:0]              dispatch_pc_in,
  input  logic [DATA_W-1:0]              dispatch_imm_in,
  input  logic [ROB_W-1:0]               dispatch_dest_in,
  input  logic [DATA_W-1:0]              dispatch_vj_in,
  input  logic [DATA_W-1:0]              dispatch_vk_in,
  input  logic [ROB_W-1:0]               dispatch_qj_in,
  input  logic [ROB_W-1:0]               dispatch_qk_in,
  input  logic                           dispatch_rj_in,
  input  logic                           dispatch_rk_in,
  input  logic [CDB_PORTS-1:0]           cdb_valid_in,
  input  logic [CDB_PORTS*ROB_W-1:0]     cdb_tag_in,
  input  logic [CDB_PORTS*DATA_W-1:0]    cdb_value_in,
  output logic                           issue_valid_out,
  input  logic                           issue_ready_in,
  output logic [DATA_W-1:0]              issue_rs1_out,
  output logic [DATA_W-1:0]              issue_rs2_out,
  output logic [DATA_W-1:0]              issue_imm_out,
  output logic [DATA_W-1:0]              issue_pc_out,
  output logic [TYPE_W-1:0]              issue_type_out,
  output logic [ROB_W-1:0]               issue_dest_out,
  output logic [$clog2(RS_DEPTH+1)-1:0]  free_count_out
);

  localparam int CNT_W = $clog2(RS_DEPTH+1);

  logic                r_busy  [RS_DEPTH];
  logic [TYPE_W-1:0]   r_type  [RS_DEPTH];
  logic [DATA_W-1:0]   r_pc    [RS_DEPTH];
  logic [DATA_W-1:0]   r_imm   [RS_DEPTH];
  logic [ROB_W-1:0]    r_dest  [RS_DEPTH];
  logic [DATA_W-1:0]   r_vj    [RS_DEPTH];
  logic [DATA_W-1:0]   r_vk    [RS_DEPTH];
  logic [ROB_W-1:0]    r_qj    [RS_DEPTH];
  logic [ROB_W-1:0]    r_qk    [RS_DEPTH];
  logic                r_rj    [RS_DEPTH];
  logic                r_rk    [RS_DEPTH];
  logic [RS_DEPTH-1:0] r_older [RS_DEPTH];

  logic [ROB_W-1:0]  w_cdb_tag [CDB_PORTS];
  logic [DATA_W-1:0] w_cdb_val [CDB_PORTS];
  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
    assign w_cdb_tag[p] = cdb_tag_in[p*ROB_W +: ROB_W];
    assign w_cdb_val[p] = cdb_value_in[p*DATA_W +: DATA_W];
  end

  logic [RS_DEPTH-1:0]          w_busy, w_ready, w_grant, w_alloc_oh;
  logic [RS_DEPTH*RS_DEPTH-1:0] w_age_flat;
  logic                         w_grant_valid, w_found, w_disp_fire, w_issue_load, w_issue_fire;
  logic [DATA_W-1:0]            w_dvj, w_dvk;
  logic                         w_drj, w_drk;

  assign dispatch_ready_out = ~&w_busy;
  assign w_disp_fire  = dispatch_valid_in & dispatch_ready_out & rdy_in & ~flush_in;
  assign w_issue_load = w_grant_valid & (~issue_valid_out | issue_ready_in);
  assign w_issue_fire = w_issue_load & rdy_in & ~flush_in;

  always_comb begin
    w_alloc_oh = '0;
    w_found    = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!w_busy[i] && !w_found) begin
        w_alloc_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  // Descending scan so that the lowest matching CDB port has the final say.
  always_comb begin
    w_dvj = dispatch_vj_in;
    w_drj = dispatch_rj_in;
    w_dvk = dispatch_vk_in;
    w_drk = dispatch_rk_in;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (!dispatch_rj_in && cdb_valid_in[p] && w_cdb_tag[p] == dispatch_qj_in) begin
        w_dvj = w_cdb_val[p];
        w_drj = 1'b1;
      end
      if (!dispatch_rk_in && cdb_valid_in[p] && w_cdb_tag[p] == dispatch_qk_in) begin
        w_dvk = w_cdb_val[p];
        w_drk = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
    logic              w_wake_j, w_wake_k;
    logic [DATA_W-1:0] w_wval_j, w_wval_k;

    assign w_busy[i]  = r_busy[i];
    assign w_ready[i] = r_busy[i] & r_rj[i] & r_rk[i];
    assign w_age_flat[i*RS_DEPTH +: RS_DEPTH] = r_older[i];

    always_comb begin
      w_wake_j = 1'b0;
      w_wake_k = 1'b0;
      w_wval_j = '0;
      w_wval_k = '0;
      for (int p = CDB_PORTS-1; p >= 0; p--) begin
        if (cdb_valid_in[p] && w_cdb_tag[p] == r_qj[i]) begin
          w_wake_j = 1'b1;
          w_wval_j = w_cdb_val[p];
        end
        if (cdb_valid_in[p] && w_cdb_tag[p] == r_qk[i]) begin
          w_wake_k = 1'b1;
          w_wval_k = w_cdb_val[p];
        end
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        r_busy[i]  <= 1'b0;
        r_type[i]  <= '0;
        r_pc[i]    <= '0;
        r_imm[i]   <= '0;
        r_dest[i]  <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= ROB_W'(ZERO_TAG);
        r_qk[i]    <= ROB_W'(ZERO_TAG);
        r_rj[i]    <= 1'b0;
        r_rk[i]    <= 1'b0;
        r_older[i] <= '0;
      end else if (flush_in) begin
        r_busy[i]  <= 1'b0;
        r_older[i] <= '0;
      end else if (rdy_in) begin
        // A new entry is youngest: clear its row, mark every busy entry older.
        if (w_disp_fire) begin
          r_older[i] <= w_alloc_oh[i] ? '0
                      : (r_older[i] & ~w_alloc_oh) | (w_alloc_oh & {RS_DEPTH{r_busy[i]}});
        end
        if (w_disp_fire && w_alloc_oh[i]) begin
          r_busy[i] <= 1'b1;
          r_type[i] <= dispatch_type_in;
          r_pc[i]   <= dispatch_pc_in;
          r_imm[i]  <= dispatch_imm_in;
          r_dest[i] <= dispatch_dest_in;
          r_qj[i]   <= dispatch_qj_in;
          r_qk[i]   <= dispatch_qk_in;
          r_vj[i]   <= w_dvj;
          r_rj[i]   <= w_drj;
          r_vk[i]   <= w_dvk;
          r_rk[i]   <= w_drk;
        end else begin
          if (w_issue_load && w_grant[i]) r_busy[i] <= 1'b0;
          if (r_busy[i] && !r_rj[i] && w_wake_j) begin
            r_vj[i] <= w_wval_j;
            r_rj[i] <= 1'b1;
          end
          if (r_busy[i] && !r_rk[i] && w_wake_k) begin
            r_vk[i] <= w_wval_k;
            r_rk[i] <= 1'b1;
          end
        end
      end
    end
  end

  rs_age_select #(.DEPTH(RS_DEPTH)) u_age_select (
    .i_ready (w_ready),
    .i_age   (w_age_flat),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  logic [DATA_W-1:0] w_sel_vj, w_sel_vk, w_sel_imm, w_sel_pc;
  logic [TYPE_W-1:0] w_sel_type;
  logic [ROB_W-1:0]  w_sel_dest;
  always_comb begin
    w_sel_vj   = '0;
    w_sel_vk   = '0;
    w_sel_imm  = '0;
    w_sel_pc   = '0;
    w_sel_type = '0;
    w_sel_dest = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_sel_vj   = w_sel_vj   | (r_vj[i]   & {DATA_W{w_grant[i]}});
      w_sel_vk   = w_sel_vk   | (r_vk[i]   & {DATA_W{w_grant[i]}});
      w_sel_imm  = w_sel_imm  | (r_imm[i]  & {DATA_W{w_grant[i]}});
      w_sel_pc   = w_sel_pc   | (r_pc[i]   & {DATA_W{w_grant[i]}});
      w_sel_type = w_sel_type | (r_type[i] & {TYPE_W{w_grant[i]}});
      w_sel_dest = w_sel_dest | (r_dest[i] & {ROB_W{w_grant[i]}});
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issue_valid_out <= 1'b0;
      issue_rs1_out   <= '0;
      issue_rs2_out   <= '0;
      issue_imm_out   <= '0;
      issue_pc_out    <= '0;
      issue_type_out  <= '0;
      issue_dest_out  <= '0;
      free_count_out  <= CNT_W'(RS_DEPTH);
    end else if (flush_in) begin
      issue_valid_out <= 1'b0;
      free_count_out  <= CNT_W'(RS_DEPTH);
    end else if (rdy_in) begin
      if (w_issue_load) begin
        issue_valid_out <= 1'b1;
        issue_rs1_out   <= w_sel_vj;
        issue_rs2_out   <= w_sel_vk;
        issue_imm_out   <= w_sel_imm;
        issue_pc_out    <= w_sel_pc;
        issue_type_out  <= w_sel_type;
        issue_dest_out  <= w_sel_dest;
      end else if (issue_ready_in) begin
        issue_valid_out <= 1'b0;
      end
      free_count_out <= free_count_out - CNT_W'(w_disp_fire) + CNT_W'(w_issue_fire);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_queue.sv
// ============================================================================
// Module : tb_alu_issue_queue
// Brief  : Directed self-checking bench for alu_issue_queue
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic        d_valid;
  logic        d_ready;
  logic [5:0]  d_type;
  logic [31:0] d_pc, d_imm, d_vj, d_vk;
  logic [3:0]  d_dest, d_qj, d_qk;
  logic        d_rj, d_rk;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_rs1, iss_rs2, iss_imm, iss_pc;
  logic [5:0]  iss_type;
  logic [3:0]  iss_dest;
  logic [4:0]  free_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .rdy_in             (rdy),
    .flush_in           (flush),
    .dispatch_valid_in  (d_valid),
    .dispatch_ready_out (d_ready),
    .dispatch_type_in   (d_type),
    .dispatch_pc_in     (d_pc),
    .dispatch_imm_in    (d_imm),
    .dispatch_dest_in   (d_dest),
    .dispatch_vj_in     (d_vj),
    .dispatch_vk_in     (d_vk),
    .dispatch_qj_in     (d_qj),
    .dispatch_qk_in     (d_qk),
    .dispatch_rj_in     (d_rj),
    .dispatch_rk_in     (d_rk),
    .cdb_valid_in       (cdb_valid),
    .cdb_tag_in         (cdb_tag),
    .cdb_value_in       (cdb_value),
    .issue_valid_out    (iss_valid),
    .issue_ready_in     (iss_ready),
    .issue_rs1_out      (iss_rs1),
    .issue_rs2_out      (iss_rs2),
    .issue_imm_out      (iss_imm),
    .issue_pc_out       (iss_pc),
    .issue_type_out     (iss_type),
    .issue_dest_out     (iss_dest),
    .free_count_out     (free_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] vj, input logic [3:0] qj, input logic rj,
                      input logic [31:0] vk, input logic rk, input logic [3:0] dest);
    d_valid = 1'b1; d_type = 6'h01; d_pc = 32'h100; d_imm = 32'h4;
    d_vj = vj; d_qj = qj; d_rj = rj; d_vk = vk; d_qk = 4'h0; d_rk = rk; d_dest = dest;
  endtask

  task automatic disp_idle();
    d_valid = 1'b0;
  endtask

  task automatic cdb(input int port, input logic [3:0] tag, input logic [31:0] val);
    cdb_valid[port] = 1'b1;
    cdb_tag[port*4 +: 4] = tag;
    cdb_value[port*32 +: 32] = val;
  endtask

  task automatic cdb_idle();
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b1;
    d_valid = 1'b0; d_type = '0; d_pc = '0; d_imm = '0; d_vj = '0; d_vk = '0;
    d_dest = '0; d_qj = '0; d_qk = '0; d_rj = 1'b0; d_rk = 1'b0;
    cdb_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", iss_valid, 0);
    check_eq("rst_free",  free_cnt, 16);
    check_eq("rst_dready", d_ready, 1);
    check_eq("rst_rs1",   iss_rs1, 0);
    rst_n = 1'b1;

    // Both operands ready: two-edge latency.
    disp(32'd5, 4'd0, 1'b1, 32'd7, 1'b1, 4'd3);
    tick(); disp_idle();
    check_eq("add_free_after_disp", free_cnt, 15);
    check_eq("add_not_yet", iss_valid, 0);
    tick();
    check_eq("add_valid", iss_valid, 1);
    check_eq("add_rs1", iss_rs1, 5);
    check_eq("add_rs2", iss_rs2, 7);
    check_eq("add_dest", iss_dest, 3);
    check_eq("add_type", iss_type, 6'h01);
    check_eq("add_free", free_cnt, 16);
    tick();
    check_eq("add_drop", iss_valid, 0);

    // Wakeup from CDB port 1 in the cycle after dispatch.
    disp(32'd0, 4'd2, 1'b0, 32'd1, 1'b1, 4'd4);
    tick(); disp_idle();
    cdb(1, 4'd2, 32'hAA);
    tick(); cdb_idle();
    check_eq("wake_not_yet", iss_valid, 0);
    tick();
    check_eq("wake_valid", iss_valid, 1);
    check_eq("wake_rs1", iss_rs1, 32'hAA);
    tick();

    // Broadcast in the dispatch cycle itself.
    disp(32'd0, 4'd2, 1'b0, 32'd1, 1'b1, 4'd6);
    cdb(1, 4'd2, 32'hAA);
    tick(); disp_idle(); cdb_idle();
    check_eq("dwake_not_yet", iss_valid, 0);
    tick();
    check_eq("dwake_valid", iss_valid, 1);
    check_eq("dwake_rs1", iss_rs1, 32'hAA);
    check_eq("dwake_dest", iss_dest, 6);
    tick();

    // Fill every entry with a waiting operand; entry i waits on tag i.
    for (int i = 0; i < 16; i++) begin
      disp(32'd0, 4'(i), 1'b0, 32'd0, 1'b1, 4'(i));
      tick();
    end
    check_eq("full_dready", d_ready, 0);
    check_eq("full_free", free_cnt, 0);
    disp(32'hDEAD, 4'd0, 1'b1, 32'd0, 1'b1, 4'hF);
    tick(); disp_idle();
    check_eq("full_ignored_free", free_cnt, 0);
    check_eq("full_ignored_noissue", iss_valid, 0);
    cdb(0, 4'd9, 32'h99);
    tick(); cdb_idle();
    tick();
    check_eq("e9_valid", iss_valid, 1);
    check_eq("e9_rs1", iss_rs1, 32'h99);
    check_eq("e9_dest", iss_dest, 9);
    check_eq("e9_free", free_cnt, 1);
    disp(32'h77, 4'd0, 1'b1, 32'd0, 1'b1, 4'd5);
    tick(); disp_idle();
    check_eq("refill_dready", d_ready, 0);
    check_eq("refill_free", free_cnt, 0);
    tick();
    check_eq("refill_rs1", iss_rs1, 32'h77);
    check_eq("refill_dest", iss_dest, 5);
    flush = 1'b1;
    tick(); flush = 1'b0;

    // Age order: ready B overtakes waiting A.
    disp(32'd0, 4'd1, 1'b0, 32'd0, 1'b1, 4'd1);
    tick();
    disp(32'hB, 4'd0, 1'b1, 32'd0, 1'b1, 4'd2);
    tick(); disp_idle();
    cdb(0, 4'd1, 32'hA1);
    tick(); cdb_idle();
    check_eq("age_b_dest", iss_dest, 2);
    check_eq("age_b_rs1", iss_rs1, 32'hB);
    tick();
    check_eq("age_a_dest", iss_dest, 1);
    check_eq("age_a_rs1", iss_rs1, 32'hA1);

    // C (index 1) is older than D (index 0); both wake together.
    disp(32'hF, 4'd0, 1'b1, 32'd0, 1'b1, 4'd9);
    tick();
    disp(32'd0, 4'd5, 1'b0, 32'd0, 1'b1, 4'd3);
    tick();
    check_eq("age_f_dest", iss_dest, 9);
    disp(32'd0, 4'd6, 1'b0, 32'd0, 1'b1, 4'd4);
    tick(); disp_idle();
    cdb(0, 4'd6, 32'hD6);
    cdb(1, 4'd5, 32'hC5);
    tick(); cdb_idle();
    tick();
    check_eq("age_c_dest", iss_dest, 3);
    check_eq("age_c_rs1", iss_rs1, 32'hC5);
    tick();
    check_eq("age_d_dest", iss_dest, 4);
    check_eq("age_d_rs1", iss_rs1, 32'hD6);
    tick();
    check_eq("age_drain", iss_valid, 0);

    // Back-pressure with two ready entries.
    iss_ready = 1'b0;
    disp(32'h11, 4'd0, 1'b1, 32'd0, 1'b1, 4'd1);
    tick();
    disp(32'h22, 4'd0, 1'b1, 32'd0, 1'b1, 4'd2);
    tick(); disp_idle();
    check_eq("bp_first", iss_dest, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("bp_hold_valid", iss_valid, 1);
      check_eq("bp_hold_rs1", iss_rs1, 32'h11);
      check_eq("bp_hold_free", free_cnt, 15);
    end
    iss_ready = 1'b1;
    tick();
    check_eq("bp_second_dest", iss_dest, 2);
    check_eq("bp_second_rs1", iss_rs1, 32'h22);
    check_eq("bp_free", free_cnt, 16);
    tick();
    check_eq("bp_drain", iss_valid, 0);

    // Flush with five busy entries, a pending issue and a dispatch.
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(32'(i + 1), 4'd0, 1'b1, 32'd0, 1'b1, 4'(i + 1));
      tick();
    end
    check_eq("pre_flush_free", free_cnt, 11);
    check_eq("pre_flush_valid", iss_valid, 1);
    flush = 1'b1;
    disp(32'h55, 4'd0, 1'b1, 32'd0, 1'b1, 4'd7);
    tick(); flush = 1'b0; disp_idle();
    check_eq("flush_valid", iss_valid, 0);
    check_eq("flush_free", free_cnt, 16);
    check_eq("flush_dready", d_ready, 1);
    iss_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("post_flush_quiet", iss_valid, 0);
    end

    // Global enable low: dispatch is held off.
    rdy = 1'b0;
    disp(32'h66, 4'd0, 1'b1, 32'd0, 1'b1, 4'd8);
    tick(); disp_idle();
    check_eq("rdy_low_free", free_cnt, 16);
    rdy = 1'b1;
    tick();
    check_eq("rdy_low_noissue", iss_valid, 0);

    // Asynchronous reset in mid-cycle.
    disp(32'h88, 4'd0, 1'b1, 32'd0, 1'b1, 4'd8);
    tick(); disp_idle();
    check_eq("arst_pre_free", free_cnt, 15);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_free", free_cnt, 16);
    check_eq("arst_valid", iss_valid, 0);
    check_eq("arst_dready", d_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    check_eq("arst_noissue", iss_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_queue.md
# alu_issue_queue

Parametrised ALU reservation station. Replaces the fixed 16-entry station with configurable depth and a configurable number of common-data-bus (CDB) wakeup ports. Adds oldest-first issue (age matrix), a same-cycle dispatch wakeup path, a registered issue handshake with back-pressure, and a pipeline flush. Sits between the decoder/dispatch stage and the ALU; the ALU and LSU broadcast results on the CDB ports.

## Interface
Parameters:
- RS_DEPTH, 16, number of entries (≥2, power of two not required)
- CDB_PORTS, 2, number of result-broadcast ports (ALU, LSU, ...)
- DATA_W, 32, operand/imm/pc width
- ROB_W, 4, reorder-buffer tag width
- TYPE_W, 6, instruction-type width

Ports:
- clk_in  in  1  clock; all state on rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; when low, state holds (except reset and flush)
- flush_in  in  1  mispredict flush
- dispatch_valid_in  in  1  dispatch request
- dispatch_ready_out  out  1  = at least one free entry (combinational from busy bits)
- dispatch_type_in, dispatch_pc_in, dispatch_imm_in  in  TYPE_W/DATA_W/DATA_W  payload
- dispatch_dest_in  in  ROB_W  destination ROB tag
- dispatch_vj_in, dispatch_vk_in  in  DATA_W  operand values
- dispatch_qj_in, dispatch_qk_in  in  ROB_W  producer tags
- dispatch_rj_in, dispatch_rk_in  in  1  operand already valid
- cdb_valid_in  in  CDB_PORTS  per-port broadcast valid
- cdb_tag_in  in  CDB_PORTS*ROB_W  packed tags, port p at [p*ROB_W +: ROB_W]
- cdb_value_in  in  CDB_PORTS*DATA_W  packed values
- issue_valid_out  out  1  issue register holds an instruction
- issue_ready_in  in  1  ALU accepts this cycle
- issue_rs1_out, issue_rs2_out, issue_imm_out, issue_pc_out  out  DATA_W  issued operands
- issue_type_out  out  TYPE_W; issue_dest_out  out  ROB_W
- free_count_out  out  $clog2(RS_DEPTH+1)  number of non-busy entries (registered)

## Operation
- Entry fields: busy, type, pc, imm, dest, vj, qj, rj, vk, qk, rk. Entry is ready when busy && rj && rk.
- Allocation: dispatch fires when dispatch_valid_in && dispatch_ready_out && rdy_in && !flush_in. It writes the lowest-index free entry.
- Dispatch wakeup: if an incoming operand is not ready and any valid CDB port matches its q tag in the same cycle, store that value with r=1.
- Wakeup: every busy entry compares qj/qk against every valid CDB port; on match, latch the value and set r. If two ports match the same tag, the lowest port wins; the tags are unique by construction, so this is only a tie-break.
- Age matrix: RS_DEPTH×RS_DEPTH bits; older[i][j]=1 means entry i is older than j. On allocating entry n: row n is cleared (n is youngest), and column n is set for all currently busy entries.
- Select: grant the ready entry that has no older ready entry (one-hot, oldest-first).
- Issue register loads when (!issue_valid_out || issue_ready_in) and a grant exists. The granted entry is freed on the same edge. Otherwise issue_valid_out drops after acceptance, or the register holds while stalled.
- Operands in the issue register are not updated by the CDB; they are complete by construction.
- Flush: on the next edge, clear all busy bits, clear issue_valid_out, reset free_count_out to RS_DEPTH, and drop any dispatch in that cycle. Flush works even when rdy_in=0.
- Simultaneous dispatch and issue of the same index cannot occur, because an allocated entry is free and a granted entry is busy. The freed slot becomes allocatable in the following cycle.
- Full: dispatch_ready_out=0, and dispatch_valid_in is ignored.

## Timing
- Reset values: every entry non-busy, age matrix 0, issue_valid_out=0, all issue data outputs 0, free_count_out=RS_DEPTH, dispatch_ready_out=1.
- Dispatch with both operands ready at edge N: eligible in cycle N+1, issue_valid_out=1 after edge N+1. Minimum latency is 2 edges.
- A CDB broadcast in cycle N makes the entry eligible in cycle N+1. The same applies to the dispatch-cycle wakeup.
- Back-to-back issue is one per cycle while issue_ready_in=1.
- rdy_in=0: no allocation, wakeup, select, or issue-register change. CDB inputs in that cycle are lost, so producers must hold them.
- Mid-operation asynchronous reset: immediate return to the reset values.

## Structure
- Shared package (rs_pkg): entry struct and its field widths, ROB_W/DATA_W/TYPE_W defaults, and the ZERO tag constant.
- One sub-module, rs_age_select: it takes the ready vector and the age matrix and produces a one-hot grant plus a valid flag. The remainder stays flat. Generate loops over RS_DEPTH and CDB_PORTS; no hand-unrolled entry logic.

## Test plan
- Reset, then dispatch {type=ADD, vj=5, vk=7, rj=rk=1, dest=3}. Expect issue_valid_out=1 two edges later with rs1=5, rs2=7, dest=3, and free_count_out returning to 16.
- Dispatch qj=2 (rj=0), then CDB port 1 broadcasts tag 2, value 0xAA in cycle N. Expect issue in N+2 with rs1=0xAA. Repeat with the broadcast in the dispatch cycle: rs1=0xAA, issued 2 edges after dispatch.
- Fill all 16 entries with rj=0 → dispatch_ready_out=0 and a 17th dispatch is ignored. Wake entry 9 → it issues, and the next dispatch lands in index 9.
- Dispatch A (not ready), then B (ready), then wake A. Expect B issued first. Then wake two entries at once → the older one issues first.
- Hold issue_ready_in=0 for 3 cycles with 2 ready entries. Expect the outputs stable and free_count_out unchanged; then release → two consecutive issues.
- flush_in asserted with 5 busy entries, a pending issue, and a simultaneous dispatch. After one edge: issue_valid_out=0, free_count_out=16, and nothing issues afterwards.
